dest_reg_pipeline: RTL and testbench
====================================

Name: dest_reg_pipeline

Overview:
Carries each instruction's destination register and write/load flags from decode through the EX, EX/MEM and MEM/WB pipeline registers. It drives the ex_mem/mem_wb destination and reg-write signals that the forwarding logic compares against source registers. It also detects load-use hazards that forwarding cannot cover, then stalls PC and IF/ID and inserts a bubble into EX. Instantiated once in the top-level datapath, beside the forwarding logic.

Parameters:
NB_REG, 5, register index width
NB_CNT, 16, stall-cycle counter width

Ports:
clock_i  in  1  system clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
enable_i  in  1  pipeline advance enable (debug step/run); low = hold all state
flush_i  in  1  branch/jump taken; decode instruction is squashed
id_write_reg_i  in  NB_REG  destination register of the instruction in ID
id_reg_write_i  in  1  instruction in ID writes the register file
id_mem_read_i  in  1  instruction in ID is a load
id_rs_i  in  NB_REG  source register A of the instruction in ID
id_rt_i  in  NB_REG  source register B of the instruction in ID
id_uses_rt_i  in  1  instruction in ID reads rt as a source
cnt_clear_i  in  1  synchronous clear of stall counter
ex_write_reg_o  out  NB_REG  EX-stage destination register
ex_mem_writeReg_o  out  NB_REG  EX/MEM destination register
mem_wb_writeReg_o  out  NB_REG  MEM/WB destination register
ex_mem_reg_write_o  out  1  EX/MEM reg-write valid
mem_wb_reg_write_o  out  1  MEM/WB reg-write valid
stall_o  out  1  hold PC and IF/ID this cycle
bubble_o  out  1  EX receives a bubble at the next edge
stall_cnt_o  out  NB_CNT  total stall cycles since reset or clear

Behaviour:
- Reset (async, reset_n_i low): all stage registers cleared (dest 0, reg_write 0, mem_read 0), FSM in RUN, stall_cnt_o 0, stall_o 0, bubble_o 0.
- Stage registers EX, EX/MEM and MEM/WB each hold {dest, reg_write, mem_read}.
- Write-enable qualification at entry: reg_write is captured as id_reg_write_i AND (id_write_reg_i != 0). A write to $0 never propagates, so downstream forwarding needs no zero check.
- Hazard (combinational): hz = ex.mem_read AND ex.dest != 0 AND (ex.dest == id_rs_i OR (id_uses_rt_i AND ex.dest == id_rt_i)).
- stall_o = hz AND NOT flush_i AND enable_i.
- bubble_o = enable_i AND (stall_o OR flush_i).
- On a rising edge with enable_i = 1:
  - MEM/WB takes EX/MEM.
  - EX/MEM takes EX.
  - EX takes the bubble (all zero) if bubble_o is 1, otherwise it takes the ID inputs.
- Latency: ID to EX/MEM outputs is 2 edges; ID to MEM/WB outputs is 3 edges.
- enable_i = 0: every register, the FSM and the counter hold. stall_o and bubble_o are 0.
- FSM, two states:
  - RUN: goes to STALL when stall_o = 1; otherwise stays in RUN.
  - STALL: returns to RUN on the next enabled edge. The load has then moved to EX/MEM and hz is necessarily 0. If hz is still 1 in STALL (a protocol violation), the design stalls again and stays in STALL.
  - Disabled edges do not change state.
- Simultaneous flush and hazard: flush wins. stall_o = 0 and a bubble is inserted, because the ID instruction is dead.
- Back-to-back loads into the same register: each is independent. At most one stall cycle per load-use pair.
- Counter:
  - Increments by 1 on each edge where stall_o = 1, and saturates at all-ones.
  - cnt_clear_i takes priority over increment and is applied even when enable_i = 0.
- Reset mid-stall: the FSM returns to RUN immediately and the bubble is discarded.

Decomposition:
- Shared package: NB_REG, the bubble constant (zero stage record), the FSM state encodings RUN = 1'b0 and STALL = 1'b1, and the stage-record field layout {dest, reg_write, mem_read}.
- One natural sub-module: pipe_stage_reg, a parameterised single stage register with async reset, enable and load-bubble select. It is instantiated three times.
- The hazard compare, FSM and counter stay in the top module.

Test Plan:
- Reset: drive reset_n_i low with nonzero inputs -> every output is 0; after release, state is RUN and stall_cnt_o is 0.
- Propagation: issue dest=5 with reg_write=1, then two NOPs -> ex_mem_writeReg_o = 5 with reg_write 1 after edge 2; mem_wb_writeReg_o = 5 after edge 3; both flags 0 one edge later.
- Zero destination: dest=0 with reg_write=1 -> ex_mem_reg_write_o and mem_wb_reg_write_o stay 0 throughout.
- Load-use stall: a load with dest=8 enters EX while ID has rs=8 -> stall_o = 1 and bubble_o = 1 for exactly 1 cycle.
  - The next EX record is zero, stall_cnt_o = 1, and the FSM goes RUN -> STALL -> RUN.
  - Repeat via id_rt_i = 8 with id_uses_rt_i = 0 -> no stall.
- Flush versus hazard: apply the hazard condition with flush_i = 1 -> stall_o = 0, bubble_o = 1, counter unchanged.
- Enable hold and counter: deassert enable_i during a hazard -> no state change and stall_o = 0. Then preload the counter to all-ones and stall -> the counter stays all-ones. Then assert cnt_clear_i -> the counter reads 0.

Source files
------------

// File: rtl/dest_reg_pipeline_pkg.sv
// Shared types for the destination-register pipeline: stage record layout,
// bubble constant and FSM state encoding.
package dest_reg_pipeline_pkg;

  localparam int NB_REG = 5;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic [NB_REG-1:0] dest;
    logic              reg_write;
    logic              mem_read;
  } stage_t;

  localparam int     STAGE_W      = $bits(stage_t);
  localparam stage_t STAGE_BUBBLE = '0;

endpackage

// File: rtl/dest_reg_pipeline_stage.sv
// One pipeline stage register: async clear, hold when disabled, and a
// select that loads the bubble record instead of the incoming data.
module pipe_stage_reg
  import dest_reg_pipeline_pkg::*;
#(
  parameter int           W      = STAGE_W,
  parameter logic [W-1:0] BUBBLE = STAGE_BUBBLE
) (
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         en_i,
  input  logic         bubble_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q;
  logic [W-1:0] stage_d;

  assign stage_d = bubble_i ? BUBBLE : d_i;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stage_q <= '0;
    end else if (en_i) begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/dest_reg_pipeline.sv
// Destination-register tracking through EX, EX/MEM and MEM/WB, plus load-use
// hazard detection (stall PC/IF-ID, bubble EX) and a saturating stall counter.
module dest_reg_pipeline #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 16
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic [NB_REG-1:0] id_write_reg_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              cnt_clear_i,
  output logic [NB_REG-1:0] ex_write_reg_o,
  output logic [NB_REG-1:0] ex_mem_writeReg_o,
  output logic [NB_REG-1:0] mem_wb_writeReg_o,
  output logic              ex_mem_reg_write_o,
  output logic              mem_wb_reg_write_o,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [NB_CNT-1:0] stall_cnt_o
);

  import dest_reg_pipeline_pkg::*;

  stage_t            id_d;
  stage_t            ex_q;
  stage_t            exm_q;
  stage_t            mw_q;
  logic              hz;
  logic              mw_mem_read_unused;
  state_t            state_q;
  state_t            state_d;
  logic [NB_CNT-1:0] cnt_q;
  logic [NB_CNT-1:0] cnt_d;

  // Writes to $0 are dropped here so forwarding never has to check for zero.
  always_comb begin
    id_d           = STAGE_BUBBLE;
    id_d.dest      = id_write_reg_i;
    id_d.reg_write = id_reg_write_i && (id_write_reg_i != '0);
    id_d.mem_read  = id_mem_read_i;
  end

  assign hz = ex_q.mem_read && (ex_q.dest != '0) &&
              ((ex_q.dest == id_rs_i) || (id_uses_rt_i && (ex_q.dest == id_rt_i)));

  // A taken branch kills the ID instruction, so it never needs to wait.
  assign stall_o  = hz && !flush_i && enable_i;
  assign bubble_o = enable_i && (stall_o || flush_i);

  pipe_stage_reg u_ex (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .en_i     (enable_i),
    .bubble_i (bubble_o),
    .d_i      (id_d),
    .q_o      (ex_q)
  );

  pipe_stage_reg u_ex_mem (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .en_i     (enable_i),
    .bubble_i (1'b0),
    .d_i      (ex_q),
    .q_o      (exm_q)
  );

  pipe_stage_reg u_mem_wb (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .en_i     (enable_i),
    .bubble_i (1'b0),
    .d_i      (exm_q),
    .q_o      (mw_q)
  );

  assign mw_mem_read_unused = mw_q.mem_read;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A hazard still present in STALL is a protocol violation; stall again.
  always_comb begin
    state_d = state_q;
    if (enable_i) begin
      case (state_q)
        RUN:     state_d = stall_o ? STALL : RUN;
        STALL:   state_d = stall_o ? STALL : RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clear_i) begin
      cnt_d = '0;
    end else if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign ex_write_reg_o     = ex_q.dest;
  assign ex_mem_writeReg_o  = exm_q.dest;
  assign ex_mem_reg_write_o = exm_q.reg_write;
  assign mem_wb_writeReg_o  = mw_q.dest;
  assign mem_wb_reg_write_o = mw_q.reg_write;
  assign stall_cnt_o        = cnt_q;

endmodule

// File: tb/tb_dest_reg_pipeline.sv
// Scoreboard bench for dest_reg_pipeline: each enabled edge pushes the record
// expected to enter EX; the three newest entries are the EX, EX/MEM, MEM/WB view.
module tb_dest_reg_pipeline;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, fl, rw, mr, urt, clr;
  logic [NB_REG-1:0] wd, rs, rt;
  logic [NB_REG-1:0] ex_dest, exm_dest, mw_dest;
  logic              exm_rw, mw_rw, stall, bubble;
  logic [NB_CNT-1:0] cnt;

  int                total = 0;
  int                bad = 0;
  logic [6:0]        sbq[$];
  logic [NB_CNT-1:0] cnt_exp;
  logic              st_exp;

  always #5 clk = ~clk;

  dest_reg_pipeline #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .clock_i           (clk),
    .reset_n_i         (rst_n),
    .enable_i          (en),
    .flush_i           (fl),
    .id_write_reg_i    (wd),
    .id_reg_write_i    (rw),
    .id_mem_read_i     (mr),
    .id_rs_i           (rs),
    .id_rt_i           (rt),
    .id_uses_rt_i      (urt),
    .cnt_clear_i       (clr),
    .ex_write_reg_o    (ex_dest),
    .ex_mem_writeReg_o (exm_dest),
    .mem_wb_writeReg_o (mw_dest),
    .ex_mem_reg_write_o(exm_rw),
    .mem_wb_reg_write_o(mw_rw),
    .stall_o           (stall),
    .bubble_o          (bubble),
    .stall_cnt_o       (cnt)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic f, input logic [4:0] d, input logic w,
                      input logic m, input logic [4:0] a, input logic [4:0] b,
                      input logic u, input logic c, input logic es, input logic eb);
    logic [6:0] rec, r_ex, r_exm, r_mw;
    @(negedge clk);
    en = e; fl = f; wd = d; rw = w; mr = m; rs = a; rt = b; urt = u; clr = c;
    #1;
    chk("stall", 32'(stall), 32'(es));
    chk("bubble", 32'(bubble), 32'(eb));
    @(posedge clk);
    #1;
    if (e) begin
      rec = eb ? 7'd0 : {d, w && (d != 5'd0), m};
      sbq.push_back(rec);
      st_exp = es;
    end
    if (c) cnt_exp = '0;
    else if (es && (cnt_exp != '1)) cnt_exp = cnt_exp + 1'b1;
    while (sbq.size() > 3) void'(sbq.pop_front());
    r_mw  = sbq[0];
    r_exm = sbq[1];
    r_ex  = sbq[2];
    chk("ex_dest", 32'(ex_dest), 32'(r_ex[6:2]));
    chk("ex_mem", 32'({exm_dest, exm_rw}), 32'(r_exm[6:1]));
    chk("mem_wb", 32'({mw_dest, mw_rw}), 32'(r_mw[6:1]));
    chk("cnt", 32'(cnt), 32'(cnt_exp));
    chk("state", 32'(dut.state_q), 32'(st_exp));
  endtask

  task automatic nop();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic load8();
    step(1, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) sbq.push_back(7'd0);
    cnt_exp = '0;
    st_exp  = 1'b0;
    rst_n = 1'b0;
    en = 1; fl = 0; wd = 7; rw = 1; mr = 1; rs = 3; rt = 3; urt = 1; clr = 0;
    #12;
    chk("rst_ex", 32'(ex_dest), 0);
    chk("rst_exm", 32'({exm_dest, exm_rw}), 0);
    chk("rst_mw", 32'({mw_dest, mw_rw}), 0);
    chk("rst_stall", 32'({stall, bubble}), 0);
    chk("rst_cnt", 32'(cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1; fl = 0; wd = 0; rw = 0; mr = 0; rs = 0; rt = 0; urt = 0; clr = 0;
    #1;
    chk("rel_state", 32'(dut.state_q), 0);
    chk("rel_cnt", 32'(cnt), 0);

    // Propagation of dest=5, then drain
    step(1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) nop();
    // Write to $0 must never be marked valid
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) nop();

    // Load-use through rs: one stall, then the held instruction proceeds
    load8();
    step(1, 0, 9, 1, 0, 8, 0, 0, 0, 1, 1);
    step(1, 0, 9, 1, 0, 8, 0, 0, 0, 0, 0);
    nop();
    // rt match ignored when rt is not a source, honoured when it is
    load8();
    step(1, 0, 10, 1, 0, 0, 8, 0, 0, 0, 0);
    load8();
    step(1, 0, 10, 1, 0, 0, 8, 1, 0, 1, 1);
    nop();
    // Load to $0 never hazards
    step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0);
    // Back-to-back loads to the same register: single stall
    load8();
    load8();
    step(1, 0, 11, 1, 0, 8, 0, 0, 0, 1, 1);
    nop();
    // Flush wins over hazard
    load8();
    step(1, 1, 12, 1, 0, 8, 0, 0, 0, 0, 1);
    nop();
    // Disabled edge during hazard holds everything
    load8();
    step(0, 1, 13, 1, 0, 8, 0, 0, 0, 0, 0);
    step(0, 0, 13, 1, 0, 8, 0, 0, 0, 0, 0);
    step(1, 0, 13, 1, 0, 8, 0, 0, 0, 1, 1);
    nop();
    // Drive counter into saturation
    for (int k = 0; k < 14; k++) begin
      load8();
      step(1, 0, 9, 1, 0, 8, 0, 0, 0, 1, 1);
    end
    chk("cnt_sat", 32'(cnt), 32'((1 << NB_CNT) - 1));
    // Clear beats a simultaneous increment
    load8();
    step(1, 0, 9, 1, 0, 8, 0, 0, 1, 1, 1);
    load8();
    step(1, 0, 9, 1, 0, 8, 0, 0, 0, 1, 1);
    // Clear applies while disabled
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("cnt_clr", 32'(cnt), 0);
    nop();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
